mem_ctrl: RTL and testbench

//  Single-port memory controller that shares the byte-wide RAM between

---
 rtl/mem_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Byte-wide single-port RAM controller shared by instruction
//               fetch and the MEM stage; MEM has fixed priority over IF.
//               Optional one-entry instruction buffer: MEM_CTRL_IBUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              is_if_q, is_if_d;
    logic [RAM_AW-1:0] base_q, base_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       acc_q, acc_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [RAM_AW-1:0] w_if_a;
    logic [RAM_AW-1:0] w_mem_a;
    logic [RAM_AW-1:0] w_issue_a;
    logic [2:0]        w_mem_n;
    logic [2:0]        w_cnt_nx;
    logic [1:0]        w_cap_idx;
    logic [31:0]       w_acc_cap;
    logic [7:0]        w_wbyte;
    logic              w_unused_hi;

    assign w_if_a      = if_addr[RAM_AW-1:0];
    assign w_mem_a     = mem_addr[RAM_AW-1:0];
    assign w_unused_hi = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};
    assign w_mem_n     = (mem_sel == 2'b00) ? 3'd1 : (mem_sel == 2'b01) ? 3'd2 : 3'd4;
    assign w_cnt_nx    = cnt_q + 3'd1;
    assign w_issue_a   = base_q + RAM_AW'(w_cnt_nx);
    assign w_wbyte     = wdata_q[{w_cnt_nx[1:0], 3'b000} +: 8];
    // Read data for byte k arrives two edges after it was issued, so the
    // byte captured when the counter reads c belongs to byte c-1.
    assign w_cap_idx   = cnt_q[1:0] - 2'd1;

    always_comb begin
        w_acc_cap = acc_q;
        w_acc_cap[{w_cap_idx, 3'b000} +: 8] = ram_din;
    end

`ifdef MEM_CTRL_IBUF_EN
    logic              ibuf_valid_q, ibuf_valid_d;
    logic [RAM_AW-1:0] ibuf_addr_q, ibuf_addr_d;
    logic [31:0]       ibuf_word_q, ibuf_word_d;
    logic [RAM_AW-1:0] w_fwd;
    logic [RAM_AW-1:0] w_bwd;
    logic              w_ibuf_hit;
    logic              w_ibuf_kill;
    logic              w_st_accept;
    logic              w_fill;

    // Modular distances catch overlap even when either range wraps.
    assign w_fwd       = w_mem_a - ibuf_addr_q;
    assign w_bwd       = ibuf_addr_q - w_mem_a;
    assign w_ibuf_hit  = ibuf_valid_q && (w_if_a == ibuf_addr_q);
    assign w_ibuf_kill = ibuf_valid_q &&
                         ((w_fwd < RAM_AW'(4)) || (w_bwd < RAM_AW'(w_mem_n)));
    assign w_st_accept = (state_q == S_IDLE) && mem_req && mem_we;
    assign w_fill      = (state_q == S_RD) && is_if_q && !if_flush && (cnt_q == n_q);

    always_comb begin
        ibuf_valid_d = ibuf_valid_q;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_word_d  = ibuf_word_q;
        if (w_fill) begin
            ibuf_valid_d = 1'b1;
            ibuf_addr_d  = base_q;
            ibuf_word_d  = w_acc_cap;
        end else if (w_st_accept && w_ibuf_kill) begin
            ibuf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibuf_valid_q <= 1'b0;
            ibuf_addr_q  <= '0;
            ibuf_word_q  <= '0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_word_q  <= ibuf_word_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        is_if_d     = is_if_q;
        base_d      = base_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    is_if_d = 1'b0;
                    base_d  = w_mem_a;
                    n_d     = w_mem_n;
                    cnt_d   = 3'd0;
                    acc_d   = '0;
                    wdata_d = mem_wdata;
                    ram_a_d = w_mem_a;
                    if (mem_we) begin
                        state_d    = S_WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d = S_RD;
                    end
                end else if (if_req) begin
`ifdef MEM_CTRL_IBUF_EN
                    if (w_ibuf_hit) begin
                        state_d   = S_DONE;
                        if_done_d = 1'b1;
                        if_inst_d = ibuf_word_q;
                    end else
`endif
                    begin
                        state_d = S_RD;
                        is_if_d = 1'b1;
                        base_d  = w_if_a;
                        n_d     = 3'd4;
                        cnt_d   = 3'd0;
                        acc_d   = '0;
                        ram_a_d = w_if_a;
                    end
                end
            end

            S_RD: begin
                if (is_if_q && if_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = w_cnt_nx;
                    if (w_cnt_nx < n_q) begin
                        ram_a_d = w_issue_a;
                    end
                    if (cnt_q != 3'd0) begin
                        acc_d = w_acc_cap;
                    end
                    if (cnt_q == n_q) begin
                        state_d = S_DONE;
                        if (is_if_q) begin
                            if_done_d = 1'b1;
                            if_inst_d = w_acc_cap;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = w_acc_cap;
                        end
                    end
                end
            end

            S_WR: begin
                if (w_cnt_nx < n_q) begin
                    cnt_d      = w_cnt_nx;
                    ram_a_d    = w_issue_a;
                    ram_dout_d = w_wbyte;
                    ram_wr_d   = 1'b1;
                end else begin
                    state_d    = S_DONE;
                    mem_done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_if_q     <= 1'b0;
            base_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            is_if_q     <= is_if_d;
            base_q      <= base_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_done      = if_done_q;
    assign if_inst      = if_inst_q;
    assign mem_done     = mem_done_q;
    assign mem_rdata    = mem_rdata_q;
    assign ram_a        = ram_a_q;
    assign ram_wr       = ram_wr_q;
    assign ram_dout     = ram_dout_q;
    assign stallreq_if  = if_req & ~if_done_q;
    assign stallreq_mem = mem_req & ~mem_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed + random bench for mem_ctrl against a byte-array
//               reference model. Honours MEM_CTRL_IBUF_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int          AW   = 17;
    localparam logic [31:0] MASK = 32'h0001_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, if_done;
    logic [31:0]   if_addr, if_inst;
    logic          mem_req, mem_we, mem_done;
    logic [1:0]    mem_sel;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic [7:0]    ram_dout, ram_din;
    logic          stallreq_if, stallreq_mem;

    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [7:0]    pre_d;
    logic [7:0]    ram [0:(1<<AW)-1];
    logic [7:0]    ram_q;

    logic [7:0]    ref_mem [0:(1<<AW)-1];
    bit            ib_v;
    logic [31:0]   ib_a;
    int            total = 0;
    int            bad   = 0;
    logic [31:0]   got_inst, got_rdata;

    mem_ctrl #(.RAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM; preload port used only while the DUT is in reset.
    always @(posedge clk) begin
        if (pre_we)      ram[pre_a] <= pre_d;
        else if (ram_wr) ram[ram_a] <= ram_dout;
        ram_q <= ram[ram_a];
    end
    assign ram_din = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a + k) & MASK];
        return v;
    endfunction

    function automatic logic [31:0] ram_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ram[(a + k) & MASK];
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a[AW-1:0];
        pre_d  = d;
        ref_mem[a & MASK] = d;
    endtask

    task automatic op(input string tag, input bit fi, input logic [31:0] fa,
                      input bit mi, input bit mwe, input logic [1:0] msel,
                      input logic [31:0] ma, input logic [31:0] mwd);
        int n, lm, lf, eif, cif, cmem, nwr;
        logic [31:0] erd, einst;
        bit hit;
        n   = (msel == 2'b00) ? 1 : (msel == 2'b01) ? 2 : 4;
        lm  = mwe ? n + 1 : n + 2;
        erd = ref_read(ma, n);
        if (mi && mwe) begin
            for (int k = 0; k < n; k++) begin
                ref_mem[(ma + k) & MASK] = mwd[8*k +: 8];
                for (int j = 0; j < 4; j++)
                    if (((ma + k) & MASK) == ((ib_a + j) & MASK)) ib_v = 1'b0;
            end
        end
        hit = 1'b0;
`ifdef MEM_CTRL_IBUF_EN
        hit = ib_v && ((fa & MASK) == ib_a);
`endif
        lf    = hit ? 1 : 6;
        eif   = mi ? lm + 1 + lf : lf;
        einst = ref_read(fa, 4);
        if (fi) begin
            ib_v = 1'b1;
            ib_a = fa & MASK;
        end

        @(negedge clk);
        if_flush = 1'b0;
        if_req = fi;  if_addr = fa;
        mem_req = mi; mem_we = mwe; mem_sel = msel; mem_addr = ma; mem_wdata = mwd;
        cif = -1; cmem = -1; nwr = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({tag, "_stall_if"},  {31'd0, stallreq_if},  {31'd0, fi && (eif != 1)});
                chk({tag, "_stall_mem"}, {31'd0, stallreq_mem}, {31'd0, mi});
            end
            if (ram_wr) nwr++;
            if (mem_req && mem_done) begin
                cmem = c; got_rdata = mem_rdata; mem_req = 1'b0;
            end
            if (if_req && if_done) begin
                cif = c; got_inst = if_inst; if_req = 1'b0;
            end
            if (!if_req && !mem_req) break;
        end
        chk({tag, "_wr_cycles"}, nwr, (mi && mwe) ? n : 0);
        if (mi) begin
            chk({tag, "_mem_lat"}, cmem, lm);
            if (mwe) chk({tag, "_ram"}, ram_read(ma, n), ref_read(ma, n));
            else     chk({tag, "_rdata"}, got_rdata, erd);
        end
        if (fi) begin
            chk({tag, "_if_lat"}, cif, eif);
            chk({tag, "_inst"}, got_inst, einst);
        end
    endtask

    initial begin
        logic [31:0] a, fa, d;
        int kind;
        rst = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
        ib_v = 1'b0; ib_a = '0; got_inst = '0; got_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_if_done",  {31'd0, if_done},  0);
        chk("rst_mem_done", {31'd0, mem_done}, 0);
        chk("rst_ram_wr",   {31'd0, ram_wr},   0);
        chk("rst_ram_a",    {15'd0, ram_a},    0);
        chk("rst_if_inst",  if_inst,   0);
        chk("rst_mem_rdata", mem_rdata, 0);

        for (int i = 0; i < 32'h300; i++) preload(i, 8'($urandom));
        for (int i = 32'h1FF00; i < 32'h20000; i++) preload(i, 8'($urandom));
        preload(32'h10, 8'h13); preload(32'h11, 8'h00);
        preload(32'h12, 8'h00); preload(32'h13, 8'h93);
        preload(32'h100, 8'hFF);
        @(negedge clk);
        pre_we = 1'b0;
        rst    = 1'b0;

        op("fetch10", 1, 32'h10, 0, 0, 2'b00, 0, 0);
        chk("fetch10_word", got_inst, 32'h9300_0013);
        op("refetch10", 1, 32'h10, 0, 0, 2'b00, 0, 0);
        op("st_b12", 0, 0, 1, 1, 2'b00, 32'h12, 32'h5A);
        op("refetch10b", 1, 32'h10, 0, 0, 2'b00, 0, 0);

        op("prio", 1, 32'h20, 1, 0, 2'b00, 32'h100, 0);
        chk("prio_rdata", got_rdata, 32'h0000_00FF);

        op("st_wrap", 0, 0, 1, 1, 2'b01, 32'h1FFFF, 32'h0000_ABCD);
        chk("wrap_lo", {24'd0, ram[17'h1FFFF]}, 32'hCD);
        chk("wrap_hi", {24'd0, ram[17'h00000]}, 32'hAB);

        // Flush two cycles into a fetch, then immediately request 0x40.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        chk("flush_c1_done", {31'd0, if_done}, 0);
        @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        op("after_flush", 1, 32'h40, 0, 0, 2'b00, 0, 0);

        // Reset in the middle of a word store, after two bytes are written.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'b10;
        mem_addr = 32'h200; mem_wdata = 32'h1122_3344;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_ram_wr",    {31'd0, ram_wr},   0);
        chk("mrst_mem_done",  {31'd0, mem_done}, 0);
        chk("mrst_ram_a",     {15'd0, ram_a},    0);
        chk("mrst_ram_dout",  {24'd0, ram_dout}, 0);
        chk("mrst_if_inst",   if_inst,   0);
        chk("mrst_mem_rdata", mem_rdata, 0);
        ref_mem[32'h200] = 8'h44;
        ref_mem[32'h201] = 8'h33;
        ib_v = 1'b0;
        @(negedge clk);
        mem_req = 1'b0; mem_we = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_ram", ram_read(32'h200, 4), ref_read(32'h200, 4));

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 32'h2F0)
                                               : $urandom_range(32'h1FFF0, 32'h1FFFF);
            a    = a | (($urandom_range(0, 1) == 1) ? 32'h0010_0000 : 32'h0);
            fa   = ($urandom_range(0, 1) == 1) ? (32'h10 + 4 * $urandom_range(0, 2))
                                               : $urandom_range(0, 32'h2F0);
            d    = $urandom;
            case (kind)
                0:       op("rnd_fetch", 1, fa, 0, 0, 2'b00, 0, 0);
                1:       op("rnd_load", 0, 0, 1, 0, 2'($urandom_range(0, 3)), a, 0);
                2:       op("rnd_store", 0, 0, 1, 1, 2'($urandom_range(0, 3)), a, d);
                default: op("rnd_both", 1, fa, 1, 1'($urandom_range(0, 1)),
                            2'($urandom_range(0, 3)), a, d);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
